// File: rtl/router_pkg.sv
// Shared router definitions: port count, select/one-hot types and port indices.
package router_pkg;

  localparam int unsigned NUM_PORTS  = 5;
  localparam int unsigned PORT_SEL_W = 3;

  typedef logic [PORT_SEL_W-1:0] port_sel_t;
  typedef logic [NUM_PORTS-1:0]  port_oh_t;

  typedef enum logic [PORT_SEL_W-1:0] {
    PORT_LOCAL = 3'd0,
    PORT_NORTH = 3'd1,
    PORT_EAST  = 3'd2,
    PORT_SOUTH = 3'd3,
    PORT_WEST  = 3'd4
  } port_id_e;

endpackage

// File: rtl/demux_1to5_if.sv
// Select request in, registered port enables out.
interface demux_1to5_if;
  import router_pkg::*;

  logic      en;
  port_sel_t select;
  port_oh_t  op;
  logic      sel_err;

  modport master (output en, output select, input op, input sel_err);
  modport slave  (input en, input select, output op, output sel_err);
endinterface

// File: rtl/demux_1to5_decode.sv
// Combinational port-index decoder: one-hot enable plus out-of-range flag.
module onehot_decode_5
  import router_pkg::*;
(
  input  port_sel_t select,
  output port_oh_t  oh,
  output logic      invalid
);

  always_comb begin
    oh      = '0;
    invalid = 1'b1;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (select == port_sel_t'(i)) begin
        oh[i]   = 1'b1;
        invalid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/demux_1to5.sv
// Registered 1-to-5 output-port enable decoder for the wormhole router crossbar.
module demux_1to5 (
  input logic          clk,
  input logic          rst_n,
  demux_1to5_if.slave  bus
);
  import router_pkg::*;

  port_oh_t dec_oh;
  logic     dec_invalid;

  onehot_decode_5 u_decode (
    .select  (bus.select),
    .oh      (dec_oh),
    .invalid (dec_invalid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.op      <= '0;
      bus.sel_err <= 1'b0;
    end else if (bus.en) begin
      bus.op      <= dec_oh;
      bus.sel_err <= dec_invalid;
    end
  end

  a_onehot0: assert property (@(posedge clk) $onehot0(bus.op));

  a_err_zero: assert property (@(posedge clk) bus.sel_err |-> (bus.op == '0));

  a_latency_valid: assert property (@(posedge clk)
    (rst_n && bus.en && (bus.select < port_sel_t'(NUM_PORTS)))
      |=> (bus.op == (port_oh_t'(1) << $past(bus.select))) && !bus.sel_err);

  a_latency_err: assert property (@(posedge clk)
    (rst_n && bus.en && (bus.select >= port_sel_t'(NUM_PORTS)))
      |=> (bus.op == '0) && bus.sel_err);

  a_hold: assert property (@(posedge clk)
    (rst_n && !bus.en) |=> $stable(bus.op) && $stable(bus.sel_err));

  a_sel_known: assert property (@(posedge clk) bus.en |-> !$isunknown(bus.select));

endmodule

// File: tb/tb_demux_1to5.sv
// Directed and random stimulus for demux_1to5, checked against a scoreboard model.
module tb_demux_1to5;
  import router_pkg::*;

  typedef struct packed {
    port_oh_t op;
    logic     err;
  } exp_t;

  logic clk;
  logic rst_n;
  demux_1to5_if bus ();

  demux_1to5 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t sb[$];
  exp_t model_q;
  int   checks;
  int   errors;

  task automatic step(input logic r, input logic e, input logic [2:0] s, input string tag);
    exp_t nxt;
    exp_t got;
    rst_n      = r;
    bus.en     = e;
    bus.select = s;
    nxt = model_q;
    if (!r) begin
      nxt.op  = 5'b00000;
      nxt.err = 1'b0;
    end else if (e) begin
      case (s)
        3'd0: nxt.op = 5'b00001;
        3'd1: nxt.op = 5'b00010;
        3'd2: nxt.op = 5'b00100;
        3'd3: nxt.op = 5'b01000;
        3'd4: nxt.op = 5'b10000;
        default: nxt.op = 5'b00000;
      endcase
      nxt.err = (s > 3'd4);
    end
    model_q = nxt;
    sb.push_back(nxt);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    checks++;
    assert (bus.op === got.op) else begin
      errors++;
      $error("FAIL %s op: got %b expected %b", tag, bus.op, got.op);
    end
    checks++;
    assert (bus.sel_err === got.err) else begin
      errors++;
      $error("FAIL %s sel_err: got %b expected %b", tag, bus.sel_err, got.err);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    model_q    = '0;
    rst_n      = 1'b0;
    bus.en     = 1'b1;
    bus.select = 3'd3;

    step(1'b0, 1'b1, PORT_SOUTH, "reset0");
    step(1'b0, 1'b1, PORT_SOUTH, "reset1");

    for (int unsigned s = 0; s < 8; s++) step(1'b1, 1'b1, 3'(s), "sweep");

    step(1'b1, 1'b1, PORT_EAST, "hold_load");
    for (int unsigned k = 0; k < 3; k++) step(1'b1, 1'b0, PORT_WEST, "hold");

    step(1'b1, 1'b1, 3'd7,       "err_set");
    step(1'b1, 1'b1, PORT_NORTH, "err_recover");

    step(1'b1, 1'b1, PORT_SOUTH, "mid_load");
    step(1'b0, 1'b1, PORT_WEST,  "mid_reset");
    step(1'b1, 1'b1, PORT_WEST,  "mid_release");

    step(1'b1, 1'b1, PORT_LOCAL, "b2b_a");
    step(1'b1, 1'b0, 3'd6,       "hold_en0");
    step(1'b0, 1'b0, PORT_EAST,  "reset_en0");

    for (int unsigned k = 0; k < 1000; k++)
      step(($urandom_range(9) != 0), 1'($urandom), 3'($urandom_range(7)), "random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
